// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling 7-segment driver: segment codes,
// the default message and a width helper.
package scroll_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } scroll_dir_e;

    // Segment codes: bit7..bit1 = a..g, bit0 = dp, active-high.
    localparam logic [7:0] SEG_SPACE = 8'h00;
    localparam logic [7:0] SEG_D     = 8'h7A;
    localparam logic [7:0] SEG_E     = 8'h9E;
    localparam logic [7:0] SEG_H     = 8'h6E;
    localparam logic [7:0] SEG_L     = 8'h1C;
    localparam logic [7:0] SEG_O     = 8'hFC;
    localparam logic [7:0] SEG_R     = 8'h0A;
    localparam logic [7:0] SEG_U     = 8'h7C;
    localparam logic [7:0] SEG_W1    = 8'h60;
    localparam logic [7:0] SEG_W2    = SEG_U;
    localparam logic [7:0] SEG_DP    = 8'h01;

    localparam int DEFAULT_MSG_LEN = 12;

    // "HELLO WOrLd." with the full stop folded into the dp of the last digit.
    localparam logic [7:0] DEFAULT_MSG [DEFAULT_MSG_LEN] = '{
        SEG_H, SEG_E, SEG_L, SEG_L, SEG_O, SEG_SPACE,
        SEG_W1, SEG_W2, SEG_O, SEG_R, SEG_L, SEG_D | SEG_DP
    };

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/msg_rom.sv
// Combinational character ROM: tape index in, segment code out; anything
// past the end of the message reads as a blank.
module msg_rom
    import scroll_pkg::*;
#(
    parameter int MSG_LEN = 12,
    parameter int IDX_W   = 4
) (
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       code
);

    always_comb begin
        code = SEG_SPACE;
        for (int i = 0; i < DEFAULT_MSG_LEN; i++) begin
            if (i < MSG_LEN && idx == IDX_W'(i)) begin
                code = DEFAULT_MSG[i];
            end
        end
    end

endmodule

// File: rtl/scroll_display.sv
// Self-running scrolling-message driver for a multiplexed 7-segment display:
// scan/step/position counters plus registered segment and anode outputs.
module scroll_display
    import scroll_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int MSG_LEN       = 12,
    parameter int SCAN_DIV      = 50000,
    parameter int STEP_TICKS    = 250,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  pause,
    input  logic                  restart,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  wrap
);

    localparam int TAPE_LEN = MSG_LEN + NUM_DIGITS;
    localparam int SC_W     = width_of(SCAN_DIV);
    localparam int ST_W     = width_of(STEP_TICKS);
    localparam int DG_W     = width_of(NUM_DIGITS);
    localparam int POS_W    = width_of(TAPE_LEN);

    localparam logic [SC_W-1:0]       SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [ST_W-1:0]       ST_LAST  = ST_W'(STEP_TICKS - 1);
    localparam logic [DG_W-1:0]       DG_LAST  = DG_W'(NUM_DIGITS - 1);
    localparam logic [POS_W-1:0]      POS_LAST = POS_W'(TAPE_LEN - 1);
    localparam logic [POS_W:0]        TAPE_EXT = (POS_W + 1)'(TAPE_LEN);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [SC_W-1:0]       r_sc;
    logic [ST_W-1:0]       r_st;
    logic [DG_W-1:0]       r_dg;
    logic [POS_W-1:0]      r_pos;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_wrap;

    logic                  w_scanTick;
    logic                  w_stepDue;
    logic [POS_W:0]        w_tapeSum;
    logic [POS_W-1:0]      w_tapeIdx;
    logic [POS_W-1:0]      w_posNext;
    logic                  w_posWraps;
    logic [NUM_DIGITS-1:0] w_anOn;
    logic [7:0]            w_char;

    // pos + dg is below 2*TAPE_LEN, so one conditional subtract gives the modulo.
    always_comb begin
        w_scanTick = (r_sc == SC_LAST);
        w_stepDue  = w_scanTick && (r_st == ST_LAST) && !pause;
        w_tapeSum  = {1'b0, r_pos} + (POS_W + 1)'(r_dg);
        w_tapeIdx  = (w_tapeSum >= TAPE_EXT) ? POS_W'(w_tapeSum - TAPE_EXT)
                                             : POS_W'(w_tapeSum);
        w_anOn     = AN_OFF ^ (NUM_DIGITS'(1) << r_dg);
        if (dir == DIR_RIGHT) begin
            w_posWraps = (r_pos == '0);
            w_posNext  = w_posWraps ? POS_LAST : r_pos - POS_W'(1);
        end else begin
            w_posWraps = (r_pos == POS_LAST);
            w_posNext  = w_posWraps ? '0 : r_pos + POS_W'(1);
        end
    end

    msg_rom #(
        .MSG_LEN (MSG_LEN),
        .IDX_W   (POS_W)
    ) u_msg_rom (
        .idx  (w_tapeIdx),
        .code (w_char)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc   <= '0;
            r_st   <= '0;
            r_dg   <= '0;
            r_pos  <= '0;
            r_seg  <= '0;
            r_an   <= AN_OFF;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (en) begin
                r_sc <= w_scanTick ? '0 : r_sc + SC_W'(1);
                if (w_scanTick) begin
                    r_dg <= (r_dg == DG_LAST) ? '0 : r_dg + DG_W'(1);
                end
                if (w_scanTick && !pause) begin
                    r_st <= (r_st == ST_LAST) ? '0 : r_st + ST_W'(1);
                end
                if (w_stepDue) begin
                    r_pos  <= w_posNext;
                    r_wrap <= w_posWraps;
                end
                r_seg <= w_char;
                r_an  <= w_anOn;
            end else begin
                r_seg <= '0;
                r_an  <= AN_OFF;
            end
            // Restart beats a coincident step and swallows its wrap pulse.
            if (restart) begin
                r_pos  <= '0;
                r_st   <= '0;
                r_wrap <= 1'b0;
            end
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_scroll_display.sv
// Directed bench for scroll_display with a short scan/step period
// (T = 16 tape positions, pos steps every 8 clocks).
module tb_scroll_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       pause;
    logic       restart;
    logic [7:0] seg;
    logic [3:0] an;
    logic       wrap;

    int testCount = 0;
    int failCount = 0;
    int wrapSeen;

    scroll_display #(
        .NUM_DIGITS    (4),
        .MSG_LEN       (12),
        .SCAN_DIV      (4),
        .STEP_TICKS    (2),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .dir     (dir),
        .pause   (pause),
        .restart (restart),
        .seg     (seg),
        .an      (an),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic dirV,
                                 input logic pauseV, input logic restartV);
        en      = enV;
        dir     = dirV;
        pause   = pauseV;
        restart = restartV;
    endtask

    // Counts negedges; after tick(k) from a release the outputs show the
    // counter state left by rising edge k-1.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick(3);
        checkOutput("reset_an", an, 4'b1111);
        checkOutput("reset_seg", seg, 8'h00);
        checkOutput("reset_wrap", wrap, 1'b0);

        // Paused from release so pos stays 0 while the digits cycle.
        rst_n = 1'b1;
        tick(1);
        checkOutput("first_an", an, 4'b1110);
        checkOutput("first_seg", seg, 8'h6E);
        tick(4);
        checkOutput("dig1_an", an, 4'b1101);
        checkOutput("dig1_seg", seg, 8'h9E);
        tick(4);
        checkOutput("dig2_an", an, 4'b1011);
        checkOutput("dig2_seg", seg, 8'h1C);
        tick(4);
        checkOutput("dig3_an", an, 4'b0111);
        checkOutput("dig3_seg", seg, 8'h1C);

        // Left scroll to pos 2, freeze, then read the full frame.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        resetDut();
        tick(16);
        checkOutput("left_pre_seg", seg, 8'hFC);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1);
        checkOutput("left_p2_d0_an", an, 4'b1110);
        checkOutput("left_p2_d0", seg, 8'h1C);
        tick(4);
        checkOutput("left_p2_d1", seg, 8'h1C);
        tick(4);
        checkOutput("left_p2_d2", seg, 8'hFC);
        tick(4);
        checkOutput("left_p2_d3", seg, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(110);
        checkOutput("left_prewrap", wrap, 1'b0);
        tick(1);
        checkOutput("left_wrap", wrap, 1'b1);
        tick(1);
        checkOutput("left_wrap_end", wrap, 1'b0);
        checkOutput("left_p0_an", an, 4'b0111);
        checkOutput("left_p0_d3", seg, 8'h1C);

        // Right scroll: first step wraps 0 -> 15.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        resetDut();
        tick(7);
        checkOutput("right_prewrap", wrap, 1'b0);
        tick(1);
        checkOutput("right_wrap", wrap, 1'b1);
        tick(1);
        checkOutput("right_wrap_end", wrap, 1'b0);
        checkOutput("right_p15_d2_an", an, 4'b1011);
        checkOutput("right_p15_d2", seg, 8'h9E);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick(4);
        checkOutput("right_p15_d3", seg, 8'h1C);
        tick(4);
        checkOutput("right_p15_d0_an", an, 4'b1110);
        checkOutput("right_p15_d0", seg, 8'h00);
        tick(4);
        checkOutput("right_p15_d1", seg, 8'h6E);

        // Pause at pos 3 for 40 cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        resetDut();
        tick(24);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        wrapSeen = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            wrapSeen += int'(wrap);
            if (i == 1) begin
                checkOutput("pause_an_a", an, 4'b1011);
                checkOutput("pause_seg_a", seg, 8'h00);
            end else if (i == 5) begin
                checkOutput("pause_an_b", an, 4'b0111);
                checkOutput("pause_seg_b", seg, 8'h60);
            end else if (i == 9) begin
                checkOutput("pause_an_c", an, 4'b1110);
                checkOutput("pause_seg_c", seg, 8'h1C);
            end else if (i == 13) begin
                checkOutput("pause_an_d", an, 4'b1101);
                checkOutput("pause_seg_d", seg, 8'hFC);
            end else if (i == 40) begin
                checkOutput("pause_an_end", an, 4'b0111);
                checkOutput("pause_seg_end", seg, 8'h60);
            end
        end
        checkOutput("pause_no_wrap", wrapSeen, 0);

        // Restart on the step edge at pos 5, then an enable gap.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        resetDut();
        tick(47);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_wrap", wrap, 1'b0);
        tick(1);
        checkOutput("restart_an", an, 4'b1110);
        checkOutput("restart_seg", seg, 8'h6E);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("dis_an_first", an, 4'b1111);
        checkOutput("dis_seg_first", seg, 8'h00);
        tick(9);
        checkOutput("dis_an_last", an, 4'b1111);
        checkOutput("dis_seg_last", seg, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        checkOutput("reen_an", an, 4'b1110);
        checkOutput("reen_seg", seg, 8'h6E);
        tick(2);
        checkOutput("reen_hold_seg", seg, 8'h6E);
        tick(1);
        checkOutput("reen_next_an", an, 4'b1101);
        checkOutput("reen_next_seg", seg, 8'h9E);

        // Asynchronous reset mid-scroll at pos 9.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        resetDut();
        tick(74);
        checkOutput("mid_an", an, 4'b1011);
        checkOutput("mid_seg", seg, 8'h7B);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_an", an, 4'b1111);
        checkOutput("async_seg", seg, 8'h00);
        checkOutput("async_wrap", wrap, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checkOutput("post_rst_an", an, 4'b1110);
        checkOutput("post_rst_seg", seg, 8'h6E);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
